// File: rtl/fir_filter_param_if.sv
// Sample, result, flush and coefficient-load signals of fir_filter_param.
// master drives samples and coefficients; slave is the filter.
interface fir_filter_param_if #(
   parameter int unsigned DW   = 8,
   parameter int unsigned CW   = 3,
   parameter int unsigned OUTW = 10
);
   logic            clr;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   x;
   logic            coef_we;
   logic [3:0]      coef_addr;
   logic [CW-1:0]   coef_data;
   logic [OUTW-1:0] dataout;
   logic            out_valid;
   logic            out_ready;
   logic            primed;

   modport master (
      output clr, in_valid, x, coef_we, coef_addr, coef_data, out_ready,
      input  in_ready, dataout, out_valid, primed
   );

   modport slave (
      input  clr, in_valid, x, coef_we, coef_addr, coef_data, out_ready,
      output in_ready, dataout, out_valid, primed
   );
endinterface

// File: rtl/fir_filter_param.sv
// Direct-form FIR, NTAPS taps, run-time loadable coefficients, 2-stage pipeline with backpressure.
// Define FIR_SAT_EN to clamp the output to 2^OUTW-1 instead of wrapping.
module fir_filter_param #(
   parameter int unsigned DW    = 8,
   parameter int unsigned CW    = 3,
   parameter int unsigned NTAPS = 5,
   parameter int unsigned OUTW  = 10,
   parameter int unsigned C0    = 5,
   parameter int unsigned C1    = 4,
   parameter int unsigned C2    = 3,
   parameter int unsigned C3    = 2,
   parameter int unsigned C4    = 1,
   parameter int unsigned C5    = 0,
   parameter int unsigned C6    = 0,
   parameter int unsigned C7    = 0,
   parameter int unsigned C8    = 0,
   parameter int unsigned C9    = 0,
   parameter int unsigned C10   = 0,
   parameter int unsigned C11   = 0,
   parameter int unsigned C12   = 0,
   parameter int unsigned C13   = 0,
   parameter int unsigned C14   = 0,
   parameter int unsigned C15   = 0
) (
   input  logic              clk,
   input  logic              rst,
   fir_filter_param_if.slave bus
);
   localparam int unsigned PW = DW + CW;
   localparam int unsigned FW = DW + CW + $clog2(NTAPS);
   localparam int unsigned SW = (FW > OUTW) ? FW : OUTW;
   localparam int unsigned NW = $clog2(NTAPS + 1);
   localparam int unsigned CInit [16] = '{C0, C1, C2, C3, C4, C5, C6, C7,
                                          C8, C9, C10, C11, C12, C13, C14, C15};
   localparam logic [SW-1:0] OutMax = (SW'(1) << OUTW) - SW'(1);

   logic [DW-1:0]   tap_q   [NTAPS];
   logic [DW-1:0]   tap_d   [NTAPS];
   logic [DW-1:0]   newtap  [NTAPS];
   logic [CW-1:0]   coef_q  [NTAPS];
   logic [CW-1:0]   coef_d  [NTAPS];
   logic [PW-1:0]   prod_q  [NTAPS];
   logic [PW-1:0]   prod_d  [NTAPS];
   logic            p_valid_q, p_valid_d;
   logic [OUTW-1:0] dataout_q, dataout_d;
   logic            out_valid_q, out_valid_d;
   logic [NW-1:0]   cnt_q, cnt_d;
   logic            stall;
   logic            accept;
   logic [FW-1:0]   sum;
   logic [SW-1:0]   sum_ext;
   logic [OUTW-1:0] sum_red;

   assign stall        = out_valid_q & ~bus.out_ready;
   assign bus.in_ready = ~stall & ~rst;
   assign accept       = bus.in_valid & bus.in_ready;

   assign bus.dataout   = dataout_q;
   assign bus.out_valid = out_valid_q;
   assign bus.primed    = (cnt_q == NW'(NTAPS));

   // Delay-line contents as they will be after this edge's shift.
   always_comb begin
      newtap[0] = bus.x;
      for (int k = 1; k < NTAPS; k++) begin
         newtap[k] = tap_q[k-1];
      end
   end

   // Stage 1: shift and multiply, using coefficients as they stand before this edge.
   always_comb begin
      tap_d     = tap_q;
      prod_d    = prod_q;
      p_valid_d = p_valid_q;
      if (bus.clr) begin
         for (int k = 0; k < NTAPS; k++) begin
            tap_d[k]  = '0;
            prod_d[k] = '0;
         end
         p_valid_d = 1'b0;
      end else if (accept) begin
         for (int k = 0; k < NTAPS; k++) begin
            tap_d[k]  = newtap[k];
            prod_d[k] = PW'(newtap[k]) * PW'(coef_q[k]);
         end
         p_valid_d = 1'b1;
      end else if (!stall) begin
         p_valid_d = 1'b0;
      end
   end

   always_comb begin
      sum = '0;
      for (int k = 0; k < NTAPS; k++) begin
         sum = sum + FW'(prod_q[k]);
      end
   end

   assign sum_ext = SW'(sum);

`ifdef FIR_SAT_EN
   assign sum_red = (sum_ext > OutMax) ? OutMax[OUTW-1:0] : sum_ext[OUTW-1:0];
`else
   assign sum_red = sum_ext[OUTW-1:0];
`endif

   // Stage 2: reduce and present; frozen while downstream holds off.
   always_comb begin
      dataout_d   = dataout_q;
      out_valid_d = out_valid_q;
      if (bus.clr) begin
         dataout_d   = '0;
         out_valid_d = 1'b0;
      end else if (!stall) begin
         dataout_d   = sum_red;
         out_valid_d = p_valid_q;
      end
   end

   // Coefficient writes are independent of clr; out-of-range indices match nothing.
   always_comb begin
      coef_d = coef_q;
      if (bus.coef_we) begin
         for (int k = 0; k < NTAPS; k++) begin
            if (bus.coef_addr == 4'(k)) begin
               coef_d[k] = bus.coef_data;
            end
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (bus.clr) begin
         cnt_d = '0;
      end else if (accept && (cnt_q != NW'(NTAPS))) begin
         cnt_d = cnt_q + NW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NTAPS; k++) begin
            tap_q[k]  <= '0;
            prod_q[k] <= '0;
            coef_q[k] <= CW'(CInit[k]);
         end
         p_valid_q   <= 1'b0;
         dataout_q   <= '0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         tap_q       <= tap_d;
         prod_q      <= prod_d;
         coef_q      <= coef_d;
         p_valid_q   <= p_valid_d;
         dataout_q   <= dataout_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
      end
   end
endmodule

// File: tb/tb_fir_filter_param.sv
// Directed bench for fir_filter_param at default parameters (coefs 5,4,3,2,1).
module tb_fir_filter_param;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   logic [9:0] q [$];

   fir_filter_param_if #(.DW(8), .CW(3), .OUTW(10)) bus ();

   fir_filter_param dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every completed output transfer.
   always @(posedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) q.push_back(bus.dataout);
   end

   initial begin
      #500us;
      $display("FAIL timeout: simulation did not finish, got no end, required end");
      $fatal(1, "timeout");
   end

   task automatic push(input logic [7:0] v);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x        = v;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_clr();
      @(negedge clk);
      bus.clr      = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.clr = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
      else n_pass++;
      n_checks++;
      if (bus.primed !== 1'b0) $display("FAIL reset_primed got %b want 0", bus.primed);
      else n_pass++;
      n_checks++;
      if (bus.dataout !== 10'd0) $display("FAIL reset_dataout got %0d want 0", bus.dataout);
      else n_pass++;
      n_checks++;
      if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready);
      else n_pass++;
   endtask

   task automatic test_impulse();
      int exp_v [6] = '{5, 4, 3, 2, 1, 0};
      logic [9:0] got;
      q.delete();
      push(8'd1);
      n_checks++;
      if (bus.out_valid !== 1'b0) $display("FAIL imp_latency1 got %b want 0", bus.out_valid);
      else n_pass++;
      push(8'd0);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.dataout !== 10'd5)
         $display("FAIL imp_latency2 got v=%b d=%0d want v=1 d=5", bus.out_valid, bus.dataout);
      else n_pass++;
      push(8'd0);
      push(8'd0);
      n_checks++;
      if (bus.primed !== 1'b0) $display("FAIL imp_primed4 got %b want 0", bus.primed);
      else n_pass++;
      push(8'd0);
      n_checks++;
      if (bus.primed !== 1'b1) $display("FAIL imp_primed5 got %b want 1", bus.primed);
      else n_pass++;
      for (int i = 0; i < 3; i++) push(8'd0);
      idle(4);
      n_checks++;
      if (q.size() != 8) $display("FAIL imp_count got %0d want 8", q.size());
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         got = 'x;
         if (i < q.size()) got = q[i];
         n_checks++;
         if (got !== 10'(exp_v[i])) $display("FAIL imp_out[%0d] got %0d want %0d", i, got, exp_v[i]);
         else n_pass++;
      end
   endtask

   task automatic test_step();
      int exp_v [7] = '{50, 90, 120, 140, 150, 150, 150};
      logic [9:0] got;
      q.delete();
      for (int i = 0; i < 7; i++) push(8'd10);
      idle(4);
      n_checks++;
      if (q.size() != 7) $display("FAIL step_count got %0d want 7", q.size());
      else n_pass++;
      for (int i = 0; i < 7; i++) begin
         got = 'x;
         if (i < q.size()) got = q[i];
         n_checks++;
         if (got !== 10'(exp_v[i])) $display("FAIL step_out[%0d] got %0d want %0d", i, got, exp_v[i]);
         else n_pass++;
      end
   endtask

   task automatic test_full_scale();
`ifdef FIR_SAT_EN
      int exp_v [7] = '{1023, 1023, 1023, 1023, 1023, 1023, 1023};
`else
      int exp_v [7] = '{251, 247, 1012, 498, 753, 753, 753};
`endif
      logic [9:0] got;
      do_clr();
      q.delete();
      for (int i = 0; i < 7; i++) push(8'd255);
      idle(4);
      n_checks++;
      if (q.size() != 7) $display("FAIL full_count got %0d want 7", q.size());
      else n_pass++;
      for (int i = 0; i < 7; i++) begin
         got = 'x;
         if (i < q.size()) got = q[i];
         n_checks++;
         if (got !== 10'(exp_v[i])) $display("FAIL full_out[%0d] got %0d want %0d", i, got, exp_v[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back_stall();
      int exp_v [8] = '{5, 14, 26, 40, 55, 70, 85, 100};
      logic [9:0] got;
      do_clr();
      q.delete();
      for (int i = 1; i <= 4; i++) push(8'(i));
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.x         = 8'd5;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", bus.in_ready);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (bus.out_valid !== 1'b1 || bus.dataout !== 10'd26)
            $display("FAIL stall_hold[%0d] got v=%b d=%0d want v=1 d=26", i, bus.out_valid,
                     bus.dataout);
         else n_pass++;
      end
      bus.out_ready = 1'b1;
      for (int i = 5; i <= 8; i++) push(8'(i));
      idle(4);
      n_checks++;
      if (q.size() != 8) $display("FAIL stall_count got %0d want 8", q.size());
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         got = 'x;
         if (i < q.size()) got = q[i];
         n_checks++;
         if (got !== 10'(exp_v[i])) $display("FAIL stall_out[%0d] got %0d want %0d", i, got, exp_v[i]);
         else n_pass++;
      end
   endtask

   task automatic test_coef_write();
      int exp_a [6] = '{7, 4, 3, 2, 1, 0};
      int exp_b [7] = '{0, 7, 5, 7, 5, 3, 1};
      logic [9:0] got;
      do_clr();
      @(negedge clk);
      bus.coef_we   = 1'b1;
      bus.coef_addr = 4'd0;
      bus.coef_data = 3'd7;
      @(negedge clk);
      bus.coef_addr = 4'd9;
      bus.coef_data = 3'd6;
      @(negedge clk);
      bus.coef_we = 1'b0;
      q.delete();
      push(8'd1);
      for (int i = 0; i < 5; i++) push(8'd0);
      idle(4);
      n_checks++;
      if (q.size() != 6) $display("FAIL coef_count got %0d want 6", q.size());
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         got = 'x;
         if (i < q.size()) got = q[i];
         n_checks++;
         if (got !== 10'(exp_a[i])) $display("FAIL coef_out[%0d] got %0d want %0d", i, got, exp_a[i]);
         else n_pass++;
      end
      // Write coef0=1 on the same edge that accepts a sample: that product keeps the old 7.
      q.delete();
      push(8'd0);
      bus.coef_we   = 1'b1;
      bus.coef_addr = 4'd0;
      bus.coef_data = 3'd1;
      push(8'd1);
      bus.coef_we = 1'b0;
      push(8'd1);
      for (int i = 0; i < 4; i++) push(8'd0);
      idle(4);
      n_checks++;
      if (q.size() != 7) $display("FAIL coef_edge_count got %0d want 7", q.size());
      else n_pass++;
      for (int i = 0; i < 7; i++) begin
         got = 'x;
         if (i < q.size()) got = q[i];
         n_checks++;
         if (got !== 10'(exp_b[i])) $display("FAIL coef_edge_out[%0d] got %0d want %0d", i, got, exp_b[i]);
         else n_pass++;
      end
      @(negedge clk);
      bus.coef_we   = 1'b1;
      bus.coef_addr = 4'd0;
      bus.coef_data = 3'd5;
      @(negedge clk);
      bus.coef_we = 1'b0;
   endtask

   task automatic check_impulse(input string tag);
      int exp_v [6] = '{5, 4, 3, 2, 1, 0};
      logic [9:0] got;
      q.delete();
      push(8'd1);
      for (int i = 0; i < 5; i++) push(8'd0);
      idle(4);
      n_checks++;
      if (q.size() != 6) $display("FAIL %s_count got %0d want 6", tag, q.size());
      else n_pass++;
      for (int i = 0; i < 6; i++) begin
         got = 'x;
         if (i < q.size()) got = q[i];
         n_checks++;
         if (got !== 10'(exp_v[i])) $display("FAIL %s_out[%0d] got %0d want %0d", tag, i, got, exp_v[i]);
         else n_pass++;
      end
   endtask

   task automatic test_rst_clr();
      for (int i = 1; i <= 5; i++) push(8'(i));
      n_checks++;
      if (bus.primed !== 1'b1 || bus.out_valid !== 1'b1)
         $display("FAIL pre_rst got p=%b v=%b want p=1 v=1", bus.primed, bus.out_valid);
      else n_pass++;
      #2;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.primed !== 1'b0 || bus.dataout !== 10'd0)
         $display("FAIL mid_rst got v=%b p=%b d=%0d want v=0 p=0 d=0", bus.out_valid, bus.primed,
                  bus.dataout);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      check_impulse("after_rst");
      for (int i = 1; i <= 5; i++) push(8'(i));
      @(negedge clk);
      bus.clr      = 1'b1;
      bus.in_valid = 1'b1;
      bus.x        = 8'd9;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.primed !== 1'b0 || bus.dataout !== 10'd0)
         $display("FAIL mid_clr got v=%b p=%b d=%0d want v=0 p=0 d=0", bus.out_valid, bus.primed,
                  bus.dataout);
      else n_pass++;
      @(negedge clk);
      bus.clr      = 1'b0;
      bus.in_valid = 1'b0;
      check_impulse("after_clr");
   endtask

   initial begin
      n_checks      = 0;
      n_pass        = 0;
      rst           = 1'b1;
      bus.clr       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.x         = '0;
      bus.coef_we   = 1'b0;
      bus.coef_addr = '0;
      bus.coef_data = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_impulse();
      test_step();
      test_full_scale();
      test_back_to_back_stall();
      test_coef_write();
      test_rst_clr();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
